pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: `clk` and `reset`, both 1-bit inputs; all state changes on the rising edge of `clk`.
REQ-002 `imem_ready`, input, 1: instruction memory has returned the word for the current `pc`.
REQ-003 `stall`, input, 1: datapath hold request; no commit while high.
REQ-004 `redirect`, input, 1: the current instruction changes flow (taken branch, J, JAL or JR).
REQ-005 `jumpAddr`, input, 32: resolved target from the external jump-target unit; bit 31 already reflects mode.
REQ-006 `syscall`, input, 1: the current instruction is SYSCALL.
REQ-007 `eret`, input, 1: the current instruction is ERET.
REQ-008 `pc`, output, 32: current instruction address.
REQ-009 `PCp4`, output, 32: sequential successor of `pc`.
REQ-010 `superbit`, output, 1: supervisor mode; always equals `pc[31]`.
REQ-011 `fetch_req`, output, 1: fetch of `pc` outstanding.
REQ-012 `instr_valid`, output, 1: the decode inputs are sampled this cycle.
REQ-013 `epc`, output, 32: exception return address.
REQ-014 `cause`, output, 2: last trap cause; 0 = none, 1 = syscall, 2 = privileged ERET, 3 = fetch timeout.

Function
REQ-015 The FSM SHALL have three states: FETCH, EXEC and TRAP.
REQ-016 FETCH: `fetch_req`=1 and `pc` held stable; `imem_ready`=1 moves to EXEC.
REQ-017 FETCH timeout: a 4-bit wait counter starts at 0 on entry to FETCH and increments each cycle with `imem_ready`=0; reaching 15 moves to TRAP with cause 3 and `epc`=`pc`.
REQ-018 EXEC: `instr_valid`=1 and `fetch_req`=0.
REQ-019 EXEC with `stall`=1 stays in EXEC with `pc` unchanged; decode inputs are ignored.
REQ-020 EXEC with `stall`=0 commits one instruction, chosen in this priority order (highest first):
- `syscall`: go to TRAP with cause 1 and `epc`=`PCp4`.
- `eret` with `superbit`=0: go to TRAP with cause 2 and `epc`=`pc`.
- `eret` with `superbit`=1: `pc`<=`epc`, go to FETCH.
- `redirect`: `pc`<=`jumpAddr`, go to FETCH.
- otherwise: `pc`<=`PCp4`, go to FETCH.
REQ-021 TRAP lasts one cycle: `pc`<=TRAP_VECTOR (32'h8000_0080), then go to FETCH; `fetch_req`=0 and `instr_valid`=0.
REQ-022 `PCp4` SHALL equal `{pc[31], pc[30:0]+31'd4}`, so increments wrap inside the current mode segment.
- 32'h7FFF_FFFC -> 32'h0000_0000.
- 32'hFFFF_FFFC -> 32'h8000_0000.
REQ-023 `epc` and `cause` SHALL change only on entry to TRAP.
REQ-024 In user mode (`superbit`=0), a `jumpAddr` with bit 31 set SHALL be loaded with bit 31 forced to 0; the block never enters supervisor mode except through TRAP or reset.
REQ-025 Any decode input asserted outside EXEC SHALL be ignored.
REQ-026 `pc[1:0]` SHALL always be 0; low bits of `jumpAddr` and `epc` are masked when loaded.

Reset
REQ-027 While `reset`=1, outputs SHALL be:
- `pc`=RESET_VECTOR (32'h8000_0000), `PCp4`=32'h8000_0004, `superbit`=1
- `epc`=0, `cause`=0, wait counter=0
- state=FETCH, `fetch_req`=0, `instr_valid`=0
REQ-028 Asserting reset mid-operation SHALL take effect at the next edge and abandon any outstanding fetch or pending trap.
REQ-029 `fetch_req` SHALL first assert on the cycle after `reset` deasserts.

Structure
REQ-030 A shared package SHALL hold:
- the state enum
- the cause codes
- RESET_VECTOR, TRAP_VECTOR and the timeout limit (15)
REQ-031 The block SHALL be a single module with no sub-modules; the jump-target unit stays external and feeds `jumpAddr`.

Verification
REQ-032 Reset then `imem_ready`=1 each cycle, no decode inputs -> `pc` sequence 8000_0000, 8000_0004, 8000_0008; `superbit`=1 throughout.
REQ-033 `pc`=8000_0010 with `syscall`=1 in EXEC -> `epc`=8000_0014, `cause`=1, then `pc`=8000_0080; followed by ERET -> `pc`=8000_0014.
REQ-034 User mode at `pc`=0000_0100 with `eret`=1 -> `cause`=2, `epc`=0000_0100, `pc`=8000_0080.
REQ-035 `pc`=0000_0200 with `redirect`=1 and `jumpAddr`=8000_0040 -> `pc`=0000_0040, `superbit`=0.
REQ-036 `imem_ready` held 0 for 15 cycles at `pc`=0000_0300 -> `cause`=3, `epc`=0000_0300, `pc`=8000_0080.
REQ-037 `pc`=7FFF_FFFC with `stall`=1 for 3 cycles then 0 -> `pc` unchanged during the stall, then 0000_0000; reset in that cycle instead -> `pc`=8000_0000.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the program-counter sequencer:
//   - state_t : sequencer FSM states (FETCH / EXEC / TRAP)
//   - cause_t : trap cause codes reported on the cause output
//   - RESET_VECTOR, TRAP_VECTOR, FETCH_TIMEOUT constants
//   - helper functions for the segment-wrapping increment and word alignment
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_SYSCALL = 2'd1,
        CAUSE_PRIV    = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } cause_t;

    localparam logic [31:0] RESET_VECTOR  = 32'h8000_0000;
    localparam logic [31:0] TRAP_VECTOR   = 32'h8000_0080;
    localparam logic [3:0]  FETCH_TIMEOUT = 4'd15;

    // Sequential successor: bit 31 (mode) is preserved, the offset wraps
    // inside the current mode segment.
    function automatic logic [31:0] seq_next(input logic [31:0] addr);
        return {addr[31], addr[30:0] + 31'd4};
    endfunction

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program counter sequencer with fetch handshake, supervisor/user mode held in
// pc[31], SYSCALL / ERET trap handling and a fetch timeout trap.
//
// Ports:
//   clk          in   clock, all state changes on rising edge
//   reset        in   synchronous active-high reset
//   imem_ready   in   instruction word for pc has arrived
//   stall        in   datapath hold request (no commit while high)
//   redirect     in   current instruction changes flow
//   jumpAddr     in   resolved flow-change target (32 bit)
//   syscall      in   current instruction is SYSCALL
//   eret         in   current instruction is ERET
//   pc           out  current instruction address
//   PCp4         out  sequential successor of pc (wraps within mode segment)
//   superbit     out  supervisor mode, equals pc[31]
//   fetch_req    out  fetch of pc outstanding
//   instr_valid  out  decode inputs sampled this cycle
//   epc          out  exception return address
//   cause        out  last trap cause (0 none, 1 syscall, 2 priv ERET, 3 timeout)
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] jumpAddr,
    input  logic        syscall,
    input  logic        eret,
    output logic [31:0] pc,
    output logic [31:0] PCp4,
    output logic        superbit,
    output logic        fetch_req,
    output logic        instr_valid,
    output logic [31:0] epc,
    output logic [1:0]  cause
);

    state_t      state_reg,  state_next;
    logic [31:0] pc_reg,     pc_next;
    logic [31:0] epc_reg,    epc_next;
    cause_t      cause_reg,  cause_next;
    logic [3:0]  wait_reg,   wait_next;

    logic [31:0] pc_seq;
    logic [31:0] jump_target;
    logic [3:0]  wait_inc;

    assign pc_seq   = seq_next(pc_reg);
    assign wait_inc = wait_reg + 4'd1;

    // User code may not promote itself: bit 31 of the target survives only
    // when already in supervisor mode.
    assign jump_target = word_align({jumpAddr[31] & pc_reg[31], jumpAddr[30:0]});

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        epc_next   = epc_reg;
        cause_next = cause_reg;
        wait_next  = '0;

        case (state_reg)
            ST_FETCH: begin
                if (imem_ready) begin
                    state_next = ST_EXEC;
                end else begin
                    wait_next = wait_inc;
                    if (wait_inc == FETCH_TIMEOUT) begin
                        state_next = ST_TRAP;
                        cause_next = CAUSE_TIMEOUT;
                        epc_next   = word_align(pc_reg);
                    end
                end
            end

            ST_EXEC: begin
                if (!stall) begin
                    if (syscall) begin
                        state_next = ST_TRAP;
                        cause_next = CAUSE_SYSCALL;
                        epc_next   = word_align(pc_seq);
                    end else if (eret && !pc_reg[31]) begin
                        state_next = ST_TRAP;
                        cause_next = CAUSE_PRIV;
                        epc_next   = word_align(pc_reg);
                    end else if (eret) begin
                        state_next = ST_FETCH;
                        pc_next    = word_align(epc_reg);
                    end else if (redirect) begin
                        state_next = ST_FETCH;
                        pc_next    = jump_target;
                    end else begin
                        state_next = ST_FETCH;
                        pc_next    = pc_seq;
                    end
                end
            end

            ST_TRAP: begin
                state_next = ST_FETCH;
                pc_next    = TRAP_VECTOR;
            end

            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_FETCH;
            pc_reg    <= RESET_VECTOR;
            epc_reg   <= '0;
            cause_reg <= CAUSE_NONE;
            wait_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            epc_reg   <= epc_next;
            cause_reg <= cause_next;
            wait_reg  <= wait_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The handshake strobes are gated by reset so that nothing is
    // requested or decoded while reset is held, and the first fetch request
    // appears as soon as reset is released.
    // ------------------------------------------------------------------
    assign pc          = pc_reg;
    assign PCp4        = pc_seq;
    assign superbit    = pc_reg[31];
    assign epc         = epc_reg;
    assign cause       = cause_reg;
    assign fetch_req   = (state_reg == ST_FETCH) && !reset;
    assign instr_valid = (state_reg == ST_EXEC)  && !reset;

endmodule
